// File: rtl/p16_uart_tx.sv
// p16_uart_tx: 8N1 UART transmitter fed by a small byte FIFO; define P16_UART_TX_PARITY_EN for 8E1 framing
module p16_uart_tx #(
  parameter int CLK_FREQ = 250000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BW  = CPB > 1 ? $clog2(CPB) : 1;
  localparam logic [BW-1:0] RELOAD = BW'(CPB - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef P16_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [7:0]    mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic [7:0]    head;
  logic          empty, push, pop, tick;
`ifdef P16_UART_TX_PARITY_EN
  logic          par;
`endif
  assign o_count = wr_ptr - rd_ptr;
  assign empty   = o_count == '0;
  assign push    = i_valid && o_ready;
  assign tick    = baud == '0;
  assign pop     = !empty && (state == IDLE || (state == STOP && tick));
  assign head    = mem[rd_ptr[AW-1:0]];
  assign wr_nxt  = wr_ptr + CW'(push);
  assign rd_nxt  = rd_ptr + CW'(pop);
  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  // FIFO pointers and registered not-full flag computed from next-state occupancy
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_ready <= 1'b1;
    end else begin
      wr_ptr  <= wr_nxt;
      rd_ptr  <= rd_nxt;
      o_ready <= (wr_nxt - rd_nxt) != CW'(DEPTH);
    end
  // Frame FSM; a pop (from IDLE or at the end of STOP) always starts a new START bit
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state  <= IDLE;
      o_tx   <= 1'b1;
      o_busy <= 1'b0;
      baud   <= '0;
      idx    <= '0;
      sh     <= '0;
`ifdef P16_UART_TX_PARITY_EN
      par    <= 1'b0;
`endif
    end else if (pop) begin
      sh     <= head;
      o_tx   <= 1'b0;
      baud   <= RELOAD;
      o_busy <= 1'b1;
      state  <= START;
`ifdef P16_UART_TX_PARITY_EN
      par    <= ^head;
`endif
    end else begin
      case (state)
        IDLE: o_tx <= 1'b1;
        START:
          if (tick) begin
            o_tx  <= sh[0];
            idx   <= '0;
            baud  <= RELOAD;
            state <= DATA;
          end else baud <= baud - 1'b1;
        DATA:
          if (!tick) baud <= baud - 1'b1;
          else begin
            baud <= RELOAD;
            if (idx != 3'd7) begin
              sh   <= sh >> 1;
              o_tx <= sh[1];
              idx  <= idx + 1'b1;
            end else begin
`ifdef P16_UART_TX_PARITY_EN
              o_tx  <= par;
              state <= PARITY;
`else
              o_tx  <= 1'b1;
              state <= STOP;
`endif
            end
          end
`ifdef P16_UART_TX_PARITY_EN
        PARITY:
          if (tick) begin
            o_tx  <= 1'b1;
            baud  <= RELOAD;
            state <= STOP;
          end else baud <= baud - 1'b1;
`endif
        STOP:
          if (tick) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else baud <= baud - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_p16_uart_tx.sv
// tb_p16_uart_tx: directed checks of framing, timing, FIFO back-pressure and reset for p16_uart_tx
module tb_p16_uart_tx;
  localparam int CPB = 26;
`ifdef P16_UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = (PAR ? 11 : 10) * CPB;
  logic       clk, rst_n, valid;
  logic [7:0] data;
  logic       o_ready, o_tx, o_busy;
  logic [2:0] o_count;
  logic [7:0] rx_q[$];
  logic [7:0] rx_byte;
  int passed, total, cyc;

  p16_uart_tx #(.CLK_FREQ(250000), .BAUD(9600), .DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_busy(o_busy), .o_count(o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int t);
    int k;
    k = (t - 1) / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (PAR == 1 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // independent line decoder: samples mid-bit on falling clock edges
  initial begin
    forever begin
      @(negedge clk);
      if (o_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_byte[i] = o_tx;
        end
        if (PAR == 1) repeat (CPB) @(negedge clk);
        repeat (CPB) @(negedge clk);
        rx_q.push_back(rx_byte);
      end
    end
  end

  task automatic send_one(input logic [7:0] b, input string tag);
    int errs;
    errs = 0;
    @(negedge clk);
    data = b;
    valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    check({tag, "_tx_t0"}, o_tx, 1);
    check({tag, "_busy_t0"}, o_busy, 0);
    for (int t = 1; t <= FL; t++) begin
      @(posedge clk);
      #1 if (o_tx !== exp_bit(b, t)) errs++;
    end
    check({tag, "_bit_errs"}, errs, 0);
    check({tag, "_busy_last"}, o_busy, 1);
    @(posedge clk);
    #1 check({tag, "_busy_fall"}, o_busy, 0);
  endtask

  task automatic wait_rx(input int k);
    for (int i = 0; i < 10 * FL && rx_q.size() < k; i++) @(negedge clk);
  endtask

  initial begin
    int errs, n;
    int acc[6];
    logic r;
    passed = 0;
    total = 0;
    cyc = 0;
    rst_n = 1'b0;
    valid = 1'b0;
    data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", o_tx, 1);
    check("rst_ready", o_ready, 1);
    check("rst_busy", o_busy, 0);
    check("rst_count", o_count, 0);
    rst_n = 1'b1;
    errs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b1 || o_count !== 3'd0) errs++;
    end
    check("idle_1000", errs, 0);

    send_one(8'h55, "b55");
    send_one(8'h80, "b80");

    rx_q.delete();
    errs = 0;
    @(negedge clk);
    data = 8'hA5;
    valid = 1'b1;
    @(posedge clk);
    #1 data = 8'h3C;
    @(posedge clk);
    #1 valid = 1'b0;
    if (o_tx !== exp_bit(8'hA5, 1)) errs++;
    for (int t = 2; t <= 2 * FL; t++) begin
      @(posedge clk);
      #1 if (o_tx !== (t <= FL ? exp_bit(8'hA5, t) : exp_bit(8'h3C, t - FL))) errs++;
    end
    check("b2b_bit_errs", errs, 0);
    check("b2b_busy_last", o_busy, 1);
    @(posedge clk);
    #1 check("b2b_busy_fall", o_busy, 0);
    wait_rx(2);
    check("b2b_rx_count", rx_q.size(), 2);
    check("b2b_rx0", rx_q.size() > 0 ? 32'(rx_q[0]) : 32'hFFFF_FFFF, 32'hA5);
    check("b2b_rx1", rx_q.size() > 1 ? 32'(rx_q[1]) : 32'hFFFF_FFFF, 32'h3C);

    rx_q.delete();
    n = 0;
    @(negedge clk);
    data = 8'h01;
    valid = 1'b1;
    for (int b = 0; b < 3000 && n < 6; b++) begin
      r = o_ready;
      @(posedge clk);
      #1 if (r) begin
        acc[n] = cyc;
        n++;
        if (n == 5) begin
          check("full_ready", o_ready, 0);
          check("full_count", o_count, 4);
        end
        data = 8'(n + 1);
        if (n == 6) valid = 1'b0;
      end
      @(negedge clk);
    end
    valid = 1'b0;
    check("full_accepted", n, 6);
    check("full_6th_timing", n == 6 ? acc[5] - acc[0] : -1, FL + 2);
    wait_rx(6);
    check("full_rx_count", rx_q.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("full_rx%0d", i), i < rx_q.size() ? 32'(rx_q[i]) : 32'hFFFF_FFFF, i + 1);
    for (int i = 0; i < 2 * FL && o_busy !== 1'b0; i++) @(negedge clk);
    check("full_busy_end", o_busy, 0);
    check("full_count_end", o_count, 0);

    @(negedge clk);
    data = 8'hFF;
    valid = 1'b1;
    @(posedge clk);
    #1 data = 8'h11;
    @(posedge clk);
    #1 data = 8'h22;
    @(posedge clk);
    #1 valid = 1'b0;
    check("mid_count_pre", o_count, 2);
    repeat (107) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", o_tx, 1);
    check("mid_rst_count", o_count, 0);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_busy", o_busy, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_count !== 3'd0) errs++;
    end
    check("mid_after_idle", errs, 0);
    rx_q.delete();

`ifdef P16_UART_TX_PARITY_EN
    send_one(8'h07, "par07");
    send_one(8'h03, "par03");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
